conv_channel_packer_12: RTL

- Streaming front-end that feeds the 12-channel 1x1 convolution layer.
- Accepts a serial, channel-interleaved pixel stream (ch0..ch11 per pixel, raster order) over a valid/ready handshake.
- Assembles each pixel's 12 channel words and presents them in parallel with a single-cycle valid_out pulse, which is the format the 12-input conv stage consumes.
- Tracks pixel position within the frame, flags frame end, and detects framing errors.

---
 rtl/conv_channel_packer_12_pkg.sv | 20 ++
 rtl/conv_channel_packer_12.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/conv_channel_packer_12_pkg.sv
// Shared definitions for the 12-channel pixel packer.
// Contents:
//   NUM_CH      - number of channel words per pixel
//   state_t     - packer FSM states (COLLECT gathers words, GAP idles)
//   pixCntWidth - width of the pixel counter for a given frame size
package conv_channel_packer_12_pkg;

  localparam int NUM_CH = 12;

  typedef enum logic {
    COLLECT = 1'b0,
    GAP     = 1'b1
  } state_t;

  // A frame of one pixel still needs a one-bit counter.
  function automatic int pixCntWidth(input int numPix);
    return (numPix < 2) ? 1 : $clog2(numPix);
  endfunction

endpackage

// File: rtl/conv_channel_packer_12.sv
// Packs a serial channel-interleaved pixel stream (ch0..ch11 per pixel,
// raster order) into one parallel 12-word pixel for the 1x1 conv stage.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   s_valid, s_ready  - input handshake; a word moves when both are high
//   s_data            - input channel word
//   s_last            - marks channel 11 of the final pixel of a frame
//   valid_out         - one-cycle pulse, Out_0..Out_11 hold a full pixel
//   Out_0..Out_11     - channel words of the most recent pixel (held)
//   frame_done        - pulses with valid_out of the frame's last pixel
//   err_last          - sticky flag for s_last in the wrong place
module conv_channel_packer_12
  import conv_channel_packer_12_pkg::*;
#(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 32,
  parameter int Gap        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [Datawidth-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 valid_out,
  output logic [Datawidth-1:0] Out_0,
  output logic [Datawidth-1:0] Out_1,
  output logic [Datawidth-1:0] Out_2,
  output logic [Datawidth-1:0] Out_3,
  output logic [Datawidth-1:0] Out_4,
  output logic [Datawidth-1:0] Out_5,
  output logic [Datawidth-1:0] Out_6,
  output logic [Datawidth-1:0] Out_7,
  output logic [Datawidth-1:0] Out_8,
  output logic [Datawidth-1:0] Out_9,
  output logic [Datawidth-1:0] Out_10,
  output logic [Datawidth-1:0] Out_11,
  output logic                 frame_done,
  output logic                 err_last
);

  localparam int              NUM_PIX  = IMG_Width * IMG_Height;
  localparam int              PW       = pixCntWidth(NUM_PIX);
  localparam logic [PW-1:0]   LAST_PIX = PW'(NUM_PIX - 1);
  localparam logic [3:0]      LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((Gap > 0) ? Gap - 1 : 0);

  state_t               state_q, state_d;
  logic [3:0]           chCnt_q, chCnt_d;
  logic [3:0]           gapCnt_q, gapCnt_d;
  logic [PW-1:0]        pixCnt_q, pixCnt_d;
  logic [Datawidth-1:0] shadow_q [NUM_CH-1];
  logic [Datawidth-1:0] shadow_d [NUM_CH-1];
  logic [Datawidth-1:0] out_q [NUM_CH];
  logic [Datawidth-1:0] out_d [NUM_CH];
  logic                 valid_q, valid_d;
  logic                 frameDone_q, frameDone_d;
  logic                 err_q, err_d;
  logic                 ready_q;
  logic                 accept;
  logic                 chDone;
  logic                 lastPix;

  // ready_q keeps s_ready low throughout reset and for the reset edge itself.
  assign s_ready = ready_q && (state_q == COLLECT);
  assign accept  = s_valid && s_ready;
  assign chDone  = accept && (chCnt_q == LAST_CH);
  assign lastPix = (pixCnt_q == LAST_PIX);

  always_comb begin
    state_d     = state_q;
    chCnt_d     = chCnt_q;
    gapCnt_d    = gapCnt_q;
    pixCnt_d    = pixCnt_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    frameDone_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int i = 0; i < NUM_CH - 1; i++) begin
            if (chCnt_q == 4'(i)) shadow_d[i] = s_data;
          end
          // s_last anywhere but channel 11 of the last pixel is a framing error.
          if (s_last && !(chDone && lastPix)) err_d = 1'b1;
          if (chDone) begin
            // Channel 11 bypasses the shadow so the pixel emerges one cycle later.
            for (int i = 0; i < NUM_CH - 1; i++) out_d[i] = shadow_q[i];
            out_d[NUM_CH-1] = s_data;
            valid_d     = 1'b1;
            frameDone_d = lastPix;
            if (lastPix && !s_last) err_d = 1'b1;
            chCnt_d  = 4'd0;
            pixCnt_d = lastPix ? '0 : pixCnt_q + PW'(1);
            if (Gap > 0) begin
              state_d  = GAP;
              gapCnt_d = 4'd0;
            end
          end else begin
            chCnt_d = chCnt_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d  = COLLECT;
          gapCnt_d = 4'd0;
        end else begin
          gapCnt_d = gapCnt_q + 4'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      chCnt_q     <= 4'd0;
      gapCnt_q    <= 4'd0;
      pixCnt_q    <= '0;
      valid_q     <= 1'b0;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++) out_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      chCnt_q     <= chCnt_d;
      gapCnt_q    <= gapCnt_d;
      pixCnt_q    <= pixCnt_d;
      valid_q     <= valid_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
      ready_q     <= 1'b1;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = frameDone_q;
  assign err_last   = err_q;
  assign Out_0      = out_q[0];
  assign Out_1      = out_q[1];
  assign Out_2      = out_q[2];
  assign Out_3      = out_q[3];
  assign Out_4      = out_q[4];
  assign Out_5      = out_q[5];
  assign Out_6      = out_q[6];
  assign Out_7      = out_q[7];
  assign Out_8      = out_q[8];
  assign Out_9      = out_q[9];
  assign Out_10     = out_q[10];
  assign Out_11     = out_q[11];

endmodule
